// File: rtl/posit_norm_stage.sv
`default_nettype none
// ============================================================================
//  Module      : posit_norm_stage
//  Description : Two-stage ready/valid pipeline that normalises a posit adder
//                mantissa by its leading-zero count and adjusts the scale.
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_norm_stage #(
    parameter int N  = 8,
    parameter int es = 4,
    parameter int SW = 8,
    localparam int M = N - es + 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [M-1:0]  in_mant,
    input  logic [N-1:0]  in_lz,
    input  logic          in_zero,
    input  logic [SW-1:0] in_scale,
    input  logic          in_sign,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_mant,
    output logic [SW-1:0] out_scale,
    output logic          out_sign,
    output logic          out_zero,
    output logic          out_sat
);

    // Scale bounds expressed in the SW+2 bit working width.
    localparam logic [SW+1:0] T_MAX = {3'b000, {(SW-1){1'b1}}};
    localparam logic [SW+1:0] T_MIN = {3'b111, {(SW-1){1'b0}}};
    localparam logic [N-1:0]  LZ_LIMIT = N'(M);

    logic          s1_valid;
    logic [M-1:0]  s1_mant;
    logic [N-1:0]  s1_lz;
    logic          s1_zero;
    logic [SW-1:0] s1_scale;
    logic          s1_sign;

    logic          in_fire;
    logic          s2_load;

    logic [M-1:0]  shifted;
    logic [SW+1:0] scale_ext;
    logic [SW+1:0] lz_ext;
    logic [SW+1:0] t;
    logic          is_zero;
    logic [M-1:0]  norm_mant;
    logic [SW-1:0] norm_scale;
    logic          norm_sat;

    assign in_ready = ~s1_valid | ~out_valid | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign s2_load  = s1_valid & (~out_valid | out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_lz    <= '0;
            s1_zero  <= 1'b0;
            s1_scale <= '0;
            s1_sign  <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_mant  <= in_mant;
                s1_lz    <= in_lz;
                s1_zero  <= in_zero;
                s1_scale <= in_scale;
                s1_sign  <= in_sign;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // lz values that would not fit the working width only occur on the zero
    // path, so truncating them here never reaches the output.
    always_comb begin
        shifted    = s1_mant << s1_lz;
        scale_ext  = {{2{s1_scale[SW-1]}}, s1_scale};
        lz_ext     = (SW+2)'(s1_lz);
        t          = scale_ext + (SW+2)'(1) - lz_ext;
        is_zero    = s1_zero | (s1_lz >= LZ_LIMIT);
        norm_mant  = shifted;
        norm_scale = t[SW-1:0];
        norm_sat   = 1'b0;
        if (is_zero) begin
            norm_mant  = '0;
            norm_scale = '0;
        end else if ($signed(t) > $signed(T_MAX)) begin
            norm_scale = {1'b0, {(SW-1){1'b1}}};
            norm_sat   = 1'b1;
        end else if ($signed(t) < $signed(T_MIN)) begin
            norm_scale = {1'b1, {(SW-1){1'b0}}};
            norm_sat   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_mant  <= '0;
            out_scale <= '0;
            out_sign  <= 1'b0;
            out_zero  <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                out_mant  <= norm_mant;
                out_scale <= norm_scale;
                out_sign  <= s1_sign;
                out_zero  <= is_zero;
                out_sat   <= norm_sat;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/posit_norm_stage.md
POSIT_NORM_STAGE -- requirements
Module: posit_norm_stage

Interface
REQ-001 Parameter N, default 8: posit word width.
REQ-002 Parameter es, default 4: posit exponent field width.
REQ-003 Parameter SW, default 8: signed scale width.
REQ-004 Derived M = N-es+4: mantissa width, bit M-1 = adder carry position, bit M-2 = hidden-bit position.
REQ-005 clk  input  1: single clock; all state on rising edge.
REQ-006 reset  input  1: asynchronous, active-high reset.
REQ-007 in_valid  input  1: upstream word present.
REQ-008 in_ready  output  1: stage accepts word this cycle.
REQ-009 in_mant  input  M: raw adder mantissa sum.
REQ-010 in_lz  input  N: leading-zero count of in_mant from the leading-one detector.
REQ-011 in_zero  input  1: detector all-zero flag (in_mant == 0).
REQ-012 in_scale  input  SW: signed scale of the larger operand.
REQ-013 in_sign  input  1: result sign.
REQ-014 out_valid  output  1: normalised word present.
REQ-015 out_ready  input  1: downstream accepts word.
REQ-016 out_mant  output  M: normalised mantissa, leading one at bit M-1.
REQ-017 out_scale  output  SW: adjusted signed scale.
REQ-018 out_sign  output  1: registered sign.
REQ-019 out_zero  output  1: result is exact zero.
REQ-020 out_sat  output  1: scale clamped at max or min.

Function
REQ-021 Two-stage pipeline: S1 registers inputs; S2 registers shift and scale result; latency 2 cycles from accept to out_valid under no backpressure.
REQ-022 Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
REQ-023 in_ready = ~s1_valid | ~s2_valid | out_ready (combinational, no in_valid dependence).
REQ-024 S2 loads from S1 when s1_valid & (~s2_valid | out_ready); S1 loads on input transfer.
REQ-025 Simultaneous input and output transfer sustains one word per cycle with no bubble.
REQ-026 While out_valid & ~out_ready, all out_* hold stable.
REQ-027 out_mant = s1_mant << s1_lz (zero-fill), width M.
REQ-028 Scale arithmetic in SW+2 bits signed: t = s1_scale + 1 - s1_lz.
REQ-029 t > 2^(SW-1)-1 -> out_scale = max, out_sat = 1; t < -2^(SW-1) -> out_scale = min, out_sat = 1; else out_scale = t, out_sat = 0.
REQ-030 s1_zero = 1, or s1_lz >= M -> out_zero = 1, out_mant = 0, out_scale = 0, out_sat = 0; out_sign passes through.
REQ-031 No combinational path from in_* to out_*.
REQ-032 Word order preserved; no word dropped or duplicated.

Reset
REQ-033 reset asserted: s1_valid = 0, s2_valid = 0 immediately, no clock needed.
REQ-034 After reset: out_valid = 0, out_mant = 0, out_scale = 0, out_sign = 0, out_zero = 0, out_sat = 0, in_ready = 1.
REQ-035 Reset mid-operation discards all in-flight words; first post-reset accept emerges after 2 cycles.

Verification
REQ-036 in_mant=8'b0100_0000, in_lz=1, in_scale=3, out_ready=1 -> 2 cycles later out_mant=8'b1000_0000, out_scale=3, out_sat=0.
REQ-037 in_mant=8'b1010_0000, in_lz=0, in_scale=5 -> out_mant=8'b1010_0000, out_scale=6.
REQ-038 in_zero=1, in_mant=0, in_lz=8, in_sign=1 -> out_zero=1, out_mant=0, out_scale=0, out_sign=1.
REQ-039 in_scale=127, in_lz=0 -> out_scale=127, out_sat=1; in_scale=-128, in_lz=5 -> out_scale=-128, out_sat=1.
REQ-040 Stream 4 words with out_ready low for cycles 3-5 -> in_ready low once both stages full, outputs held, all 4 words delivered in order.
REQ-041 reset asserted with both stages valid -> out_valid=0 same cycle, in_ready=1, no stale word after release.
